// File: rtl/seq_fsm_run_arbiter.sv
// seq_fsm_run_arbiter
//   Shares one five-state sequence FSM among NREQ requesters. A round-robin
//   arbiter picks a requester, the FSM is pulsed into reset for one cycle,
//   then a fixed five-step stimulus program walks it S0->S1->S2->S3->S4->S0
//   while its Q output is checked against the expected code for each step.
//   At the end of the run a one-cycle done pulse reports pass/fail.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req[NREQ]       level request per requester
//   grant[NREQ]     one-hot grant, held FRST..DONE, zero when idle
//   busy            high in any state except IDLE
//   done            one-cycle pulse in DONE
//   pass            1 when all five steps matched (valid with done, held)
//   fail_step[3]    first mismatching step 0..4, 7 when passed (held)
//   fsm_rstN        active-low reset to the shared FSM
//   fsm_a/b/c/d     stimulus inputs to the FSM
//   fsm_q[3]        FSM output under check
//   run_cnt, err_cnt  saturating completed-run / failed-run counters
module seq_fsm_run_arbiter #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_step,
  output logic             fsm_rstN,
  output logic             fsm_a,
  output logic             fsm_b,
  output logic             fsm_c,
  output logic [3:0]       fsm_d,
  input  logic [2:0]       fsm_q,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] LAST_STEP = 3'd4;
  localparam logic [2:0] NO_FAIL   = 3'd7;

  typedef enum logic [1:0] {IDLE, FRST, RUN, DONE} state_t;

  state_t            state_q;
  logic [2:0]        step_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [NREQ-1:0]   grant_q;
  logic              done_q;
  logic              pass_q;
  logic [2:0]        fail_step_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              run_err_q;
  logic [2:0]        run_fail_q;

  // Stimulus program: inputs and expected Q for the current step.
  logic              step_a, step_b, step_c;
  logic [3:0]        step_d;
  logic [2:0]        step_exp;

  always_comb begin
    step_a   = 1'b0;
    step_b   = 1'b0;
    step_c   = 1'b0;
    step_d   = 4'b0000;
    step_exp = 3'b000;
    case (step_q)
      3'd0: begin step_a = 1'b1; step_b = 1'b1;                step_exp = 3'b001; end
      3'd1: begin step_a = 1'b1; step_c = 1'b1; step_d = 4'b0001; step_exp = 3'b011; end
      3'd2: begin step_a = 1'b1; step_b = 1'b1; step_c = 1'b1; step_exp = 3'b101; end
      3'd3: begin step_d = 4'b1111;                            step_exp = 3'b000; end
      3'd4: begin step_d = 4'b0011;                            step_exp = 3'b010; end
      default: ;
    endcase
  end

  // Round-robin search: first set req bit starting at ptr+1, wrapping.
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic [NREQ-1:0]   win_onehot;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = PTR_W'((int'(ptr_q) + off) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  // Run bookkeeping for the step closing at this edge. The step-4 result is
  // folded in directly so DONE reports the complete run.
  logic              mismatch;
  logic              run_err_d;
  logic [2:0]        run_fail_d;
  logic [CNT_W-1:0]  run_cnt_d;
  logic [CNT_W-1:0]  err_cnt_d;

  always_comb begin
    mismatch   = (fsm_q != step_exp);
    run_err_d  = run_err_q | mismatch;
    run_fail_d = run_err_q ? run_fail_q : (mismatch ? step_q : NO_FAIL);
    run_cnt_d  = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
    err_cnt_d  = (err_cnt_q == '1 || !run_err_d) ? err_cnt_q : err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      ptr_q       <= PTR_W'(NREQ - 1);
      grant_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= NO_FAIL;
      run_cnt_q   <= '0;
      err_cnt_q   <= '0;
      run_err_q   <= 1'b0;
      run_fail_q  <= NO_FAIL;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_onehot;
            ptr_q   <= win_idx;
            state_q <= FRST;
          end
        end
        FRST: begin
          step_q     <= 3'd0;
          run_err_q  <= 1'b0;
          run_fail_q <= NO_FAIL;
          state_q    <= RUN;
        end
        RUN: begin
          run_err_q  <= run_err_d;
          run_fail_q <= run_fail_d;
          if (step_q == LAST_STEP) begin
            // Results and counters update on entry to DONE so they are
            // visible together with the done pulse.
            done_q      <= 1'b1;
            pass_q      <= ~run_err_d;
            fail_step_q <= run_fail_d;
            run_cnt_q   <= run_cnt_d;
            err_cnt_q   <= err_cnt_d;
            state_q     <= DONE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;
  assign run_cnt   = run_cnt_q;
  assign err_cnt   = err_cnt_q;

  // FSM reset follows rst directly so the FSM is held while rst is high.
  assign fsm_rstN  = ~rst & (state_q != FRST);
  assign fsm_a     = (state_q == RUN) & step_a;
  assign fsm_b     = (state_q == RUN) & step_b;
  assign fsm_c     = (state_q == RUN) & step_c;
  assign fsm_d     = (state_q == RUN) ? step_d : 4'b0000;

endmodule

// File: tb/tb_seq_fsm_run_arbiter.sv
module tb_seq_fsm_run_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       err_inj;

  // Main instance (16-bit counters)
  logic [1:0]  grant;
  logic        busy, done, pass, fsm_rstN, fsm_a, fsm_b, fsm_c;
  logic [2:0]  fail_step, fsm_q;
  logic [3:0]  fsm_d;
  logic [15:0] run_cnt, err_cnt;

  // Saturation instance (2-bit counters), same stimulus
  logic [1:0]  s_grant;
  logic        s_busy, s_done, s_pass, s_rstN, s_a, s_b, s_c;
  logic [2:0]  s_fail_step, s_q;
  logic [3:0]  s_d;
  logic [1:0]  s_run_cnt, s_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared FSM: expected Q for each program row,
  // with optional corruption of steps 2 and 4.
  function automatic logic [2:0] model_q(input logic a, input logic b, input logic c,
                                         input logic [3:0] d, input logic inj);
    case ({a, b, c, d})
      7'b110_0000: model_q = 3'b001;
      7'b101_0001: model_q = 3'b011;
      7'b111_0000: model_q = inj ? 3'b100 : 3'b101;
      7'b000_1111: model_q = 3'b000;
      7'b000_0011: model_q = inj ? 3'b111 : 3'b010;
      default:     model_q = 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] step_inputs(input int k);
    case (k)
      0: step_inputs = 7'b110_0000;
      1: step_inputs = 7'b101_0001;
      2: step_inputs = 7'b111_0000;
      3: step_inputs = 7'b000_1111;
      4: step_inputs = 7'b000_0011;
      default: step_inputs = 7'b000_0000;
    endcase
  endfunction

  assign fsm_q = model_q(fsm_a, fsm_b, fsm_c, fsm_d, err_inj);
  assign s_q   = model_q(s_a, s_b, s_c, s_d, err_inj);

  seq_fsm_run_arbiter #(.NREQ(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy), .done(done),
    .pass(pass), .fail_step(fail_step), .fsm_rstN(fsm_rstN), .fsm_a(fsm_a),
    .fsm_b(fsm_b), .fsm_c(fsm_c), .fsm_d(fsm_d), .fsm_q(fsm_q),
    .run_cnt(run_cnt), .err_cnt(err_cnt)
  );

  seq_fsm_run_arbiter #(.NREQ(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req(req), .grant(s_grant), .busy(s_busy), .done(s_done),
    .pass(s_pass), .fail_step(s_fail_step), .fsm_rstN(s_rstN), .fsm_a(s_a),
    .fsm_b(s_b), .fsm_c(s_c), .fsm_d(s_d), .fsm_q(s_q),
    .run_cnt(s_run_cnt), .err_cnt(s_err_cnt)
  );

  // Observation record of one run
  int          o_glen, o_rlow, o_runs, o_in_bad;
  logic        o_done;
  logic [1:0]  o_grant;
  logic        o_pass;
  logic [2:0]  o_fs;
  logic [15:0] o_run, o_err;
  logic [1:0]  o_srun, o_serr;
  logic [2:0]  o_qs [0:4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Called in IDLE with req already applied; follows the run until done or
  // a cycle budget expires, recording what it sees. Returns in the DONE cycle.
  task automatic observe(input logic [1:0] hold);
    o_glen = 0; o_rlow = 0; o_runs = 0; o_in_bad = 0; o_done = 1'b0;
    o_grant = '0; o_pass = 1'b0; o_fs = '0; o_run = '0; o_err = '0;
    o_srun = '0; o_serr = '0;
    for (int i = 0; i < 5; i++) o_qs[i] = 3'bxxx;
    tick();
    req = hold;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (grant != 2'b00) o_glen++;
      if (!fsm_rstN) o_rlow++;
      if (busy && fsm_rstN && !done) begin
        if (o_runs < 5) begin
          o_qs[o_runs] = fsm_q;
          if ({fsm_a, fsm_b, fsm_c, fsm_d} !== step_inputs(o_runs)) o_in_bad++;
        end
        o_runs++;
      end
      if (done) begin
        o_done = 1'b1; o_grant = grant; o_pass = pass; o_fs = fail_step;
        o_run = run_cnt; o_err = err_cnt; o_srun = s_run_cnt; o_serr = s_err_cnt;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; err_inj = 1'b0;
    tick(); tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b want=0", pass); end
    checks++; if (fail_step !== 3'd7) begin failures++; $display("FAIL reset_fail_step got=%0d want=7", fail_step); end
    checks++; if (run_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", run_cnt, err_cnt); end
    checks++; if (fsm_rstN !== 1'b0) begin failures++; $display("FAIL reset_fsm_rstN_held got=%b want=0", fsm_rstN); end
    rst = 1'b0;
    tick();
    checks++; if (fsm_rstN !== 1'b1) begin failures++; $display("FAIL idle_fsm_rstN got=%b want=1", fsm_rstN); end
    checks++; if ({fsm_a, fsm_b, fsm_c, fsm_d} !== 7'd0) begin failures++; $display("FAIL idle_inputs got=%b want=0000000", {fsm_a, fsm_b, fsm_c, fsm_d}); end
    $display("test_reset done");
  endtask

  task automatic test_pass_run();
    do_reset();
    req = 2'b01;
    observe(2'b00);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL pass_done_seen got=%b want=1", o_done); end
    checks++; if (o_glen != 7) begin failures++; $display("FAIL pass_grant_len got=%0d want=7", o_glen); end
    checks++; if (o_grant !== 2'b01) begin failures++; $display("FAIL pass_grant got=%b want=01", o_grant); end
    checks++; if (o_rlow != 1) begin failures++; $display("FAIL pass_rstN_low got=%0d want=1", o_rlow); end
    checks++; if (o_runs != 5) begin failures++; $display("FAIL pass_run_cycles got=%0d want=5", o_runs); end
    checks++; if (o_in_bad != 0) begin failures++; $display("FAIL pass_step_inputs got=%0d_bad want=0", o_in_bad); end
    checks++; if ({o_qs[0], o_qs[1], o_qs[2], o_qs[3], o_qs[4]} !== {3'b001, 3'b011, 3'b101, 3'b000, 3'b010})
      begin failures++; $display("FAIL pass_q_seq got=%b %b %b %b %b want=001 011 101 000 010", o_qs[0], o_qs[1], o_qs[2], o_qs[3], o_qs[4]); end
    checks++; if (o_pass !== 1'b1 || o_fs !== 3'd7) begin failures++; $display("FAIL pass_result got=%b/%0d want=1/7", o_pass, o_fs); end
    checks++; if (o_run !== 16'd1 || o_err !== 16'd0) begin failures++; $display("FAIL pass_counters got=%0d/%0d want=1/0", o_run, o_err); end
    tick();
    checks++; if (busy !== 1'b0 || grant !== 2'b00 || done !== 1'b0) begin failures++; $display("FAIL pass_after_idle got=busy%b grant%b done%b want=0 00 0", busy, grant, done); end
    checks++; if (pass !== 1'b1 || fail_step !== 3'd7) begin failures++; $display("FAIL pass_hold got=%b/%0d want=1/7", pass, fail_step); end
    $display("test_pass_run done");
  endtask

  task automatic test_mid_run_reset();
    int dones;
    dones = 0;
    req = 2'b01;
    tick();            // FRST
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();          // steps 0..3
      if (done) dones++;
    end
    rst = 1'b1;
    tick();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=grant%b busy%b want=00 0", grant, busy); end
    checks++; if (fsm_rstN !== 1'b0) begin failures++; $display("FAIL midrst_fsm_rstN got=%b want=0", fsm_rstN); end
    checks++; if (run_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_counters got=%0d/%0d want=0/0", run_cnt, err_cnt); end
    if (done) dones++;
    tick();
    if (done) dones++;
    checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    rst = 1'b0;
    req = 2'b11;
    observe(2'b00);
    checks++; if (o_done !== 1'b1 || o_grant !== 2'b01) begin failures++; $display("FAIL midrst_first_grant got=%b/%b want=1/01", o_done, o_grant); end
    checks++; if (o_run !== 16'd1) begin failures++; $display("FAIL midrst_run_cnt got=%0d want=1", o_run); end
    tick();
    $display("test_mid_run_reset done");
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    req = 2'b11;
    for (int r = 0; r < 4; r++) begin
      want = (r % 2 == 0) ? 2'b01 : 2'b10;
      observe(2'b11);
      checks++; if (o_done !== 1'b1 || o_grant !== want) begin failures++; $display("FAIL rr_grant_%0d got=%b/%b want=1/%b", r, o_done, o_grant, want); end
      tick();
      if (r == 3) req = 2'b00;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_gap_%0d got=%b want=0", r, busy); end
      $display("rr run %0d grant=%b", r, o_grant);
    end
    checks++; if (run_cnt !== 16'd4) begin failures++; $display("FAIL rr_run_cnt got=%0d want=4", run_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_stays_idle got=%b want=0", busy); end
    $display("test_round_robin done");
  endtask

  task automatic test_error_injection();
    do_reset();
    err_inj = 1'b1;
    req = 2'b01;
    observe(2'b00);
    checks++; if (o_done !== 1'b1 || o_pass !== 1'b0) begin failures++; $display("FAIL err_pass got=%b/%b want=1/0", o_done, o_pass); end
    checks++; if (o_fs !== 3'd2) begin failures++; $display("FAIL err_fail_step got=%0d want=2", o_fs); end
    checks++; if (o_err !== 16'd1 || o_run !== 16'd1) begin failures++; $display("FAIL err_counters got=%0d/%0d want=1/1", o_run, o_err); end
    checks++; if (o_runs != 5) begin failures++; $display("FAIL err_run_cycles got=%0d want=5", o_runs); end
    tick();
    checks++; if (pass !== 1'b0 || fail_step !== 3'd2) begin failures++; $display("FAIL err_hold got=%b/%0d want=0/2", pass, fail_step); end
    err_inj = 1'b0;
    $display("test_error_injection done");
  endtask

  task automatic test_request_drop();
    do_reset();
    req = 2'b01;
    observe(2'b00);    // req0 released during FRST
    checks++; if (o_done !== 1'b1 || o_grant !== 2'b01) begin failures++; $display("FAIL drop_done got=%b/%b want=1/01", o_done, o_grant); end
    checks++; if (o_pass !== 1'b1) begin failures++; $display("FAIL drop_pass got=%b want=1", o_pass); end
    tick();
    $display("test_request_drop done");
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    do_reset();
    err_inj = 1'b1;
    for (int r = 0; r < 5; r++) begin
      want = (r >= 2) ? 2'd3 : 2'(r + 1);
      req = 2'b01;
      observe(2'b00);
      checks++; if (o_srun !== want || o_serr !== want) begin failures++; $display("FAIL sat_run_%0d got=%0d/%0d want=%0d/%0d", r, o_srun, o_serr, want, want); end
      tick();
      $display("sat run %0d run_cnt=%0d err_cnt=%0d", r, o_srun, o_serr);
    end
    checks++; if (run_cnt !== 16'd5 || err_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide_counters got=%0d/%0d want=5/5", run_cnt, err_cnt); end
    err_inj = 1'b0;
    $display("test_saturation done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    err_inj = 1'b0;
    test_reset();
    test_pass_run();
    test_mid_run_reset();
    test_round_robin();
    test_error_injection();
    test_request_drop();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
